csr_sequencer: RTL and testbench
================================

CSR_SEQUENCER -- requirements
Module: csr_sequencer

Interface
REQ-001 SHALL have parameter TRAP_VECTOR, default 32'h4, giving the PC loaded on trap entry.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports start  input  1  (begin one SYSTEM-class instruction) and instr  input  32  (instruction word).
REQ-005 SHALL have ports rs1_val  input  32  (rs1 register value) and pc  input  32  (PC of instr).
REQ-006 SHALL have ports csr_rdata  input  32  (CSR read data) and csr_invalid  input  1  (CSR address unimplemented).
REQ-007 SHALL have ports csr_addr  output  12, bus  output  32, read  output  1, write  output  1 and write_type  output  2, which drive the CSR file.
REQ-008 SHALL have ports trap  output  1, trap_cause  output  5 and ret  output  1, which are CSR-file trap-entry and return strobes.
REQ-009 SHALL have ports rd_we  output  1, rd_addr  output  5 and rd_data  output  32, which form the register-file write port.
REQ-010 SHALL have ports busy  output  1, done  output  1 (one-cycle completion) and next_pc  output  32 (valid while done).

Function
REQ-011 SHALL use the FSM states IDLE, DECODE, READ, WRITE, TRAP, RET and DONE.
REQ-012 SHALL, in IDLE with start=1, latch instr, rs1_val and pc and go to DECODE; start SHALL be ignored while busy.
REQ-013 SHALL hold busy=1 in every state except IDLE.
REQ-014 SHALL decode in DECODE as follows:
- opcode 7'b1110011 with funct3 in {001,010,011,101,110,111} -> READ.
- funct3 000, imm 12'h000 -> TRAP, cause 11.
- funct3 000, imm 12'h001 -> TRAP, cause 3.
- funct3 000, imm 12'h302 with rs1=rd=0 -> RET.
- anything else -> TRAP, cause 2.
REQ-015 SHALL, in READ, drive csr_addr=instr[31:20] and read=1.
- csr_invalid=1 -> TRAP, cause 2.
- otherwise latch csr_rdata as old value and go to WRITE.
REQ-016 SHALL set the write enable as: write_en = (funct3[1:0]==01) or (instr[19:15]!=0).
REQ-017 SHALL, in WRITE, trap with cause 2 when write_en=1 and csr_addr[11:10]==2'b11 (read-only CSR); in that case write=0 and rd_we=0.
REQ-018 SHALL otherwise, in WRITE, drive csr_addr, write=write_en and write_type=funct3[1:0].
- bus = rs1_val when funct3[2]=0.
- bus = {27'b0, instr[19:15]} when funct3[2]=1.
- rd_we=1 only when rd!=0, with rd_addr=rd and rd_data=old value.
- next state DONE.
REQ-019 SHALL, in TRAP, assert trap=1 for exactly one cycle with the latched cause on trap_cause and bus=latched pc, then go to DONE.
REQ-020 SHALL, in RET, drive csr_addr=12'h341 and read=1, latch csr_rdata as the return target, assert ret=1 for one cycle, then go to DONE.
REQ-021 SHALL, in DONE, assert done=1 for one cycle and then return to IDLE, with next_pc:
- pc+4 (mod 2^32) after a CSR op.
- TRAP_VECTOR after a trap.
- the latched mepc after MRET.
REQ-022 SHALL take the following cycles from the start edge to done: 4 for a CSR op, 4 for a CSR-address trap, 5 for a read-only write trap, 3 for ECALL/EBREAK/illegal-decode traps, and 3 for MRET.
REQ-023 SHALL drive read, write, trap, ret, rd_we and done to 0, and csr_addr, bus, write_type, trap_cause, rd_addr and rd_data to 0, in every state where they are not specified above.
REQ-024 SHALL never assert trap, ret or write in the same cycle as each other.

Reset
REQ-025 SHALL, with rst=1 at a clock edge, enter IDLE and clear all latched values; every output SHALL be 0 in the following cycle, including when reset arrives mid-instruction.
REQ-026 SHALL give rst priority over start at the same edge.

Verification
REQ-027 SHALL be checked with CSRRW x5, mscratch(0x340), rs1_val=0xDEADBEEF, csr_rdata=0x12345678 -> cycle 3: write=1, write_type=01, bus=0xDEADBEEF, rd_we=1, rd_addr=5, rd_data=0x12345678; cycle 4: done=1, next_pc=pc+4.
REQ-028 SHALL be checked with CSRRS x0, mstatus, rs1 field=0 -> read=1 in cycle 2, write=0 and rd_we=0 in cycle 3, done in cycle 4.
REQ-029 SHALL be checked with ECALL at pc=0x100 -> cycle 2: trap=1, trap_cause=11, bus=0x100; cycle 3: done=1, next_pc=0x4.
REQ-030 SHALL be checked with CSRRW on csr 0x7C0 and csr_invalid=1 -> cycle 3: trap=1, trap_cause=2; write is never asserted.
REQ-031 SHALL be checked with MRET and csr_rdata=0x200 while csr_addr=0x341 -> cycle 2: ret=1; cycle 3: done=1, next_pc=0x200.
REQ-032 SHALL be checked with rst asserted in the WRITE state -> the next cycle has all outputs 0 and busy=0, and a fresh start is accepted immediately afterwards.

Source files
------------

// File: rtl/csr_if.sv
// CSR-file bus between the SYSTEM-instruction sequencer (master) and the CSR file (slave):
// access strobes, address/data, and trap-entry/return strobes.
interface csr_if;
  logic [11:0] csr_addr;
  logic [31:0] bus;
  logic        read;
  logic        write;
  logic [1:0]  write_type;
  logic [31:0] csr_rdata;
  logic        csr_invalid;
  logic        trap;
  logic [4:0]  trap_cause;
  logic        ret;

  modport master (
    output csr_addr, bus, read, write, write_type, trap, trap_cause, ret,
    input  csr_rdata, csr_invalid
  );

  modport slave (
    input  csr_addr, bus, read, write, write_type, trap, trap_cause, ret,
    output csr_rdata, csr_invalid
  );
endinterface

// File: rtl/csr_sequencer.sv
// Multi-cycle sequencer for RISC-V SYSTEM instructions: Zicsr read/modify/write,
// ECALL/EBREAK/illegal traps and MRET. All outputs are registered.
module csr_sequencer #(
  parameter logic [31:0] TRAP_VECTOR = 32'h4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_val,
  input  logic [31:0] pc,
  csr_if.master       csr,
  output logic        rd_we,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] next_pc
);
  typedef enum logic [2:0] {IDLE, DECODE, READ, WRITE, TRAP, RET, DONE} state_t;

  localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
  localparam logic [11:0] CSR_MEPC   = 12'h341;

  state_t      state;
  logic [31:0] instr_q;
  logic [31:0] rs1_q;
  logic [31:0] pc_q;

  logic [2:0]  funct3;
  logic [4:0]  rs1_f;
  logic [4:0]  rd_f;
  logic [11:0] csr_f;
  logic        is_system;
  logic        is_csr_op;
  logic        is_mret;
  logic        write_en;
  logic        ro_write;
  logic [4:0]  decode_cause;

  assign funct3    = instr_q[14:12];
  assign rs1_f     = instr_q[19:15];
  assign rd_f      = instr_q[11:7];
  assign csr_f     = instr_q[31:20];
  assign is_system = (instr_q[6:0] == OPC_SYSTEM);
  assign is_csr_op = is_system && (funct3 != 3'b000) && (funct3 != 3'b100);
  assign is_mret   = is_system && (funct3 == 3'b000) && (csr_f == 12'h302) &&
                     (rs1_f == 5'd0) && (rd_f == 5'd0);
  assign write_en  = (funct3[1:0] == 2'b01) || (rs1_f != 5'd0);
  // CSR addresses with [11:10]==2'b11 are read-only; writing one is illegal.
  assign ro_write  = write_en && (csr_f[11:10] == 2'b11);

  // NOTE: every branch must assign decode_cause, so it gets a default first;
  // otherwise synthesis infers a latch to hold the previous value.
  always_comb begin
    decode_cause = 5'd2;
    if (is_system && funct3 == 3'b000 && csr_f == 12'h000)      decode_cause = 5'd11;
    else if (is_system && funct3 == 3'b000 && csr_f == 12'h001) decode_cause = 5'd3;
  end

  // Outputs are computed on the edge entering a state, so they are valid for the
  // whole cycle the FSM sits in that state.
  // NOTE: all state here uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      instr_q        <= '0;
      rs1_q          <= '0;
      pc_q           <= '0;
      csr.csr_addr   <= '0;
      csr.bus        <= '0;
      csr.read       <= 1'b0;
      csr.write      <= 1'b0;
      csr.write_type <= '0;
      csr.trap       <= 1'b0;
      csr.trap_cause <= '0;
      csr.ret        <= 1'b0;
      rd_we          <= 1'b0;
      rd_addr        <= '0;
      rd_data        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      next_pc        <= '0;
    end else begin
      csr.csr_addr   <= '0;
      csr.bus        <= '0;
      csr.read       <= 1'b0;
      csr.write      <= 1'b0;
      csr.write_type <= '0;
      csr.trap       <= 1'b0;
      csr.trap_cause <= '0;
      csr.ret        <= 1'b0;
      rd_we          <= 1'b0;
      rd_addr        <= '0;
      rd_data        <= '0;
      busy           <= 1'b1;
      done           <= 1'b0;
      next_pc        <= '0;

      unique case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            instr_q <= instr;
            rs1_q   <= rs1_val;
            pc_q    <= pc;
            busy    <= 1'b1;
            state   <= DECODE;
          end
        end
        DECODE: begin
          if (is_csr_op) begin
            csr.csr_addr <= csr_f;
            csr.read     <= 1'b1;
            state        <= READ;
          end else if (is_mret) begin
            csr.csr_addr <= CSR_MEPC;
            csr.read     <= 1'b1;
            csr.ret      <= 1'b1;
            state        <= RET;
          end else begin
            csr.trap       <= 1'b1;
            csr.trap_cause <= decode_cause;
            csr.bus        <= pc_q;
            state          <= TRAP;
          end
        end
        READ: begin
          if (csr.csr_invalid) begin
            csr.trap       <= 1'b1;
            csr.trap_cause <= 5'd2;
            csr.bus        <= pc_q;
            state          <= TRAP;
          end else begin
            state <= WRITE;
            if (!ro_write) begin
              csr.csr_addr   <= csr_f;
              csr.write      <= write_en;
              csr.write_type <= funct3[1:0];
              csr.bus        <= funct3[2] ? {27'b0, rs1_f} : rs1_q;
              rd_we          <= (rd_f != 5'd0);
              rd_addr        <= rd_f;
              rd_data        <= (rd_f != 5'd0) ? csr.csr_rdata : '0;
            end
          end
        end
        WRITE: begin
          if (ro_write) begin
            csr.trap       <= 1'b1;
            csr.trap_cause <= 5'd2;
            csr.bus        <= pc_q;
            state          <= TRAP;
          end else begin
            done    <= 1'b1;
            next_pc <= pc_q + 32'd4;
            state   <= DONE;
          end
        end
        TRAP: begin
          done    <= 1'b1;
          next_pc <= TRAP_VECTOR;
          state   <= DONE;
        end
        RET: begin
          done    <= 1'b1;
          next_pc <= csr.csr_rdata;
          state   <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_csr_sequencer.sv
// Self-checking bench for csr_sequencer: a transaction-level model predicts every
// output on every cycle, plus literal spot checks for the documented scenarios.
module tb_csr_sequencer;
  localparam logic [31:0] TV     = 32'h4;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;

  typedef struct packed {
    logic [11:0] csr_addr;
    logic [31:0] bus;
    logic        read;
    logic        write;
    logic [1:0]  write_type;
    logic        trap;
    logic [4:0]  trap_cause;
    logic        ret;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        busy;
    logic        done;
    logic [31:0] next_pc;
  } out_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] instr;
  logic [31:0] rs1_val;
  logic [31:0] pc;
  logic        rd_we;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        busy;
  logic        done;
  logic [31:0] next_pc;

  logic [31:0] rdata_v;
  logic [31:0] mepc_v;
  logic        invalid_v;

  csr_if cif ();

  // CSR file stand-in: mepc is returned at 0x341, everything else reads rdata_v.
  assign cif.csr_rdata   = (cif.csr_addr == 12'h341) ? mepc_v : rdata_v;
  assign cif.csr_invalid = invalid_v;

  csr_sequencer dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .instr   (instr),
    .rs1_val (rs1_val),
    .pc      (pc),
    .csr     (cif.master),
    .rd_we   (rd_we),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy),
    .done    (done),
    .next_pc (next_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  out_t exp_tab [int];
  out_t obs [int];
  out_t cur;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    cur            = '0;
    cur.csr_addr   = cif.csr_addr;
    cur.bus        = cif.bus;
    cur.read       = cif.read;
    cur.write      = cif.write;
    cur.write_type = cif.write_type;
    cur.trap       = cif.trap;
    cur.trap_cause = cif.trap_cause;
    cur.ret        = cif.ret;
    cur.rd_we      = rd_we;
    cur.rd_addr    = rd_addr;
    cur.rd_data    = rd_data;
    cur.busy       = busy;
    cur.done       = done;
    cur.next_pc    = next_pc;
  end

  // Every cycle: compare against the model; cycles with no prediction must be idle.
  always @(negedge clk) begin
    out_t e;
    if (cyc >= 1) begin
      e = exp_tab.exists(cyc) ? exp_tab[cyc] : '0;
      obs[cyc] = cur;
      checks++;
      if (cur !== e) begin
        errors++;
        $display("FAIL cycle %0d outputs: got %h want %h", cyc, cur, e);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  function automatic out_t busy_only();
    out_t o = '0;
    o.busy = 1'b1;
    return o;
  endfunction

  function automatic out_t trap_out(input logic [4:0] cause, input logic [31:0] p);
    out_t o = busy_only();
    o.trap       = 1'b1;
    o.trap_cause = cause;
    o.bus        = p;
    return o;
  endfunction

  function automatic out_t done_out(input logic [31:0] npc);
    out_t o = busy_only();
    o.done    = 1'b1;
    o.next_pc = npc;
    return o;
  endfunction

  // Instruction-level model: classify the instruction, then list the per-cycle outputs.
  task automatic model_txn(input logic [31:0] i, r1, p, rdata, mepc, input bit inv,
                           input int base, output int len);
    out_t        q[$];
    out_t        o;
    logic [2:0]  f3  = i[14:12];
    logic [11:0] imm = i[31:20];
    logic [4:0]  rs  = i[19:15];
    logic [4:0]  rd  = i[11:7];
    bit          sys = (i[6:0] == 7'h73);
    bit          we;
    q.push_back(busy_only());
    if (sys && f3 != 3'd0 && f3 != 3'd4) begin
      o = busy_only(); o.csr_addr = imm; o.read = 1'b1;
      q.push_back(o);
      we = (f3[1:0] == 2'b01) || (rs != 5'd0);
      if (inv) begin
        q.push_back(trap_out(5'd2, p));
        q.push_back(done_out(TV));
      end else if (we && imm[11:10] == 2'b11) begin
        q.push_back(busy_only());
        q.push_back(trap_out(5'd2, p));
        q.push_back(done_out(TV));
      end else begin
        o = busy_only();
        o.csr_addr   = imm;
        o.write      = we;
        o.write_type = f3[1:0];
        o.bus        = f3[2] ? {27'b0, rs} : r1;
        if (rd != 5'd0) begin
          o.rd_we = 1'b1; o.rd_addr = rd; o.rd_data = rdata;
        end
        q.push_back(o);
        q.push_back(done_out(p + 32'd4));
      end
    end else if (sys && f3 == 3'd0 && imm == 12'h000) begin
      q.push_back(trap_out(5'd11, p));
      q.push_back(done_out(TV));
    end else if (sys && f3 == 3'd0 && imm == 12'h001) begin
      q.push_back(trap_out(5'd3, p));
      q.push_back(done_out(TV));
    end else if (sys && f3 == 3'd0 && imm == 12'h302 && rs == 5'd0 && rd == 5'd0) begin
      o = busy_only(); o.csr_addr = 12'h341; o.read = 1'b1; o.ret = 1'b1;
      q.push_back(o);
      q.push_back(done_out(mepc));
    end else begin
      q.push_back(trap_out(5'd2, p));
      q.push_back(done_out(TV));
    end
    len = q.size();
    for (int k = 0; k < len; k++) exp_tab[base + 1 + k] = q[k];
  endtask

  // Called just after a rising edge; start is sampled at the next edge (cycle base+1).
  // rst_at>0 asserts reset so that edge base+rst_at sees it; poke_at>0 pulses start while busy.
  task automatic run(input logic [31:0] i, r1, p, rdata, mepc, input bit inv,
                     input int rst_at, input int poke_at, output int base);
    int len;
    int last;
    instr = i; rs1_val = r1; pc = p;
    rdata_v = rdata; mepc_v = mepc; invalid_v = inv;
    start = 1'b1;
    base  = cyc;
    model_txn(i, r1, p, rdata, mepc, inv, base, len);
    if (rst_at > 0)
      for (int k = rst_at; k <= len; k++) exp_tab.delete(base + k);
    last = (rst_at > 0) ? rst_at : len + 1;
    for (int k = 1; k <= last; k++) begin
      @(posedge clk); #1;
      start = (k == poke_at);
      if (k == poke_at) instr = ECALL;
      if (rst_at > 0 && k == rst_at - 1) rst = 1'b1;
      if (rst_at > 0 && k == rst_at) rst = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int b_rst;
    int c;
    rst = 1'b1; start = 1'b0; instr = '0; rs1_val = '0; pc = '0;
    rdata_v = '0; mepc_v = '0; invalid_v = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("reset busy", {31'b0, obs[2].busy}, 32'd0);
    check("reset outputs zero", {31'b0, (obs[2] != '0)}, 32'd0);

    // CSRRW x5, mscratch, x1
    run(32'h3400_92F3, 32'hDEAD_BEEF, 32'h0000_1000, 32'h1234_5678, 32'h0, 1'b0, 0, 0, b);
    check("csrrw write",      {31'b0, obs[b+3].write}, 32'd1);
    check("csrrw write_type", {30'b0, obs[b+3].write_type}, 32'd1);
    check("csrrw bus",        obs[b+3].bus, 32'hDEAD_BEEF);
    check("csrrw rd_we",      {31'b0, obs[b+3].rd_we}, 32'd1);
    check("csrrw rd_addr",    {27'b0, obs[b+3].rd_addr}, 32'd5);
    check("csrrw rd_data",    obs[b+3].rd_data, 32'h1234_5678);
    check("csrrw done",       {31'b0, obs[b+4].done}, 32'd1);
    check("csrrw next_pc",    obs[b+4].next_pc, 32'h0000_1004);

    // CSRRS x0, mstatus, x0 (read-only access), with a start pulse while busy
    run(32'h3000_2073, 32'h0000_FFFF, 32'h0000_2000, 32'hAAAA_5555, 32'h0, 1'b0, 0, 2, b);
    check("csrrs read",  {31'b0, obs[b+2].read}, 32'd1);
    check("csrrs write", {31'b0, obs[b+3].write}, 32'd0);
    check("csrrs rd_we", {31'b0, obs[b+3].rd_we}, 32'd0);
    check("csrrs done",  {31'b0, obs[b+4].done}, 32'd1);

    // ECALL at 0x100
    run(ECALL, 32'h0, 32'h0000_0100, 32'h0, 32'h0, 1'b0, 0, 0, b);
    check("ecall trap",    {31'b0, obs[b+2].trap}, 32'd1);
    check("ecall cause",   {27'b0, obs[b+2].trap_cause}, 32'd11);
    check("ecall bus",     obs[b+2].bus, 32'h0000_0100);
    check("ecall done",    {31'b0, obs[b+3].done}, 32'd1);
    check("ecall next_pc", obs[b+3].next_pc, 32'h0000_0004);

    // CSRRW on unimplemented CSR 0x7C0
    run(32'h7C00_92F3, 32'h1111_2222, 32'h0000_0300, 32'h0, 32'h0, 1'b1, 0, 0, b);
    check("invalid trap",  {31'b0, obs[b+3].trap}, 32'd1);
    check("invalid cause", {27'b0, obs[b+3].trap_cause}, 32'd2);
    check("invalid never write",
          {31'b0, obs[b+1].write | obs[b+2].write | obs[b+3].write | obs[b+4].write}, 32'd0);

    // MRET with mepc=0x200
    run(MRET, 32'h0, 32'h0000_0400, 32'hBAD0_BAD0, 32'h0000_0200, 1'b0, 0, 0, b);
    check("mret ret",     {31'b0, obs[b+2].ret}, 32'd1);
    check("mret done",    {31'b0, obs[b+3].done}, 32'd1);
    check("mret next_pc", obs[b+3].next_pc, 32'h0000_0200);

    // EBREAK, illegal opcode, SYSTEM funct3=100
    run(EBREAK, 32'h0, 32'h0000_0500, 32'h0, 32'h0, 1'b0, 0, 0, b);
    check("ebreak cause", {27'b0, obs[b+2].trap_cause}, 32'd3);
    run(32'h0020_81B3, 32'h0, 32'h0000_0600, 32'h0, 32'h0, 1'b0, 0, 0, b);
    check("illegal cause", {27'b0, obs[b+2].trap_cause}, 32'd2);
    run(32'h0000_4073, 32'h0, 32'h0000_0700, 32'h0, 32'h0, 1'b0, 0, 0, b);

    // CSRRW x1, mhartid, x2: write to a read-only CSR
    run(32'hF141_10F3, 32'h5, 32'h0000_0800, 32'h0000_0007, 32'h0, 1'b0, 0, 0, b);
    check("ro write",     {31'b0, obs[b+3].write}, 32'd0);
    check("ro rd_we",     {31'b0, obs[b+3].rd_we}, 32'd0);
    check("ro trap",      {31'b0, obs[b+4].trap}, 32'd1);
    check("ro done",      {31'b0, obs[b+5].done}, 32'd1);
    check("ro next_pc",   obs[b+5].next_pc, 32'h0000_0004);

    // CSRRSI x3, mhartid, 0: read of a read-only CSR is legal
    run(32'hF140_61F3, 32'h0, 32'h0000_0900, 32'h0000_0042, 32'h0, 1'b0, 0, 0, b);
    check("rsi rd_data", obs[b+3].rd_data, 32'h0000_0042);

    // CSRRCI x0, mie, 0x1F
    run(32'h305F_F073, 32'hFFFF_FFFF, 32'h0000_0A00, 32'h0000_0888, 32'h0, 1'b0, 0, 0, b);
    check("rci bus",        obs[b+3].bus, 32'h0000_001F);
    check("rci write_type", {30'b0, obs[b+3].write_type}, 32'd3);

    // PC wrap on completion
    run(32'h3400_92F3, 32'h1, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 0, 0, b);
    check("wrap next_pc", obs[b+4].next_pc, 32'h0000_0000);

    // Reset while in WRITE, then an immediate fresh ECALL
    run(32'h3400_92F3, 32'hCAFE_F00D, 32'h0000_0C00, 32'h0000_1234, 32'h0, 1'b0, 4, 0, b_rst);
    run(ECALL, 32'h0, 32'h0000_0D00, 32'h0, 32'h0, 1'b0, 0, 0, b);
    check("rst write cycle write", {31'b0, obs[b_rst+3].write}, 32'd1);
    check("rst outputs zero",      {31'b0, (obs[b_rst+4] != '0)}, 32'd0);
    check("rst fresh start trap",  {31'b0, obs[b+2].trap}, 32'd1);
    check("rst fresh start pc",    obs[b+2].bus, 32'h0000_0D00);

    // rst and start at the same edge: reset wins
    c = cyc;
    rst = 1'b1; start = 1'b1; instr = ECALL;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst priority busy c+1", {31'b0, obs[c+1].busy}, 32'd0);
    check("rst priority busy c+2", {31'b0, obs[c+2].busy}, 32'd0);

    repeat (2) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
